fifo_read_stream_adapter: RTL
=============================

// Module: fifo_read_stream_adapter
// PURPOSE
//   Sits directly downstream of the write-delay FIFO read port (rdreq/empty/q).
//   Converts it into a valid/ready stream with registered outputs. Holds a small
//   skid/prefetch buffer so throughput is full even when FIFO read data returns
//   READ_LATENCY cycles after rdreq. There is no combinational path from out_ready
//   to fifo_rdreq.
// PARAMETERS
//   WIDTH         32  data width (matches FIFO WIDTH)
//   READ_LATENCY  0   cycles from fifo_rdreq to valid fifo_q; legal values 0,1,2
//                     (0 = show-ahead: fifo_q is valid while !fifo_empty)
//   DEPTH         -   localparam = READ_LATENCY+2, buffer entries
// PORTS
//   clock       in   1              single clock, posedge
//   rst         in   1              asynchronous, active-high reset
//   fifo_rdreq  out  1              pop request to FIFO
//   fifo_empty  in   1              FIFO empty
//   fifo_q      in   WIDTH          FIFO read data
//   out_valid   out  1              out_data holds a valid item
//   out_ready   in   1              consumer accepts; transfer = out_valid & out_ready
//   out_data    out  WIDTH          head of buffer
//   occupancy   out  $clog2(DEPTH+1)  buffered items, excluding in-flight reads
// BEHAVIOUR
// - Reset (async assert, sync release): occupancy=0, rd/wr pointers=0, in-flight
//   shift register cleared, out_valid=0, out_data=0. fifo_rdreq=0 while rst=1.
// - Reset mid-operation discards buffered items and in-flight reads. The FIFO must
//   be reset in the same cycle.
// - In-flight tracking: shift register of READ_LATENCY bits, fed by fifo_rdreq.
//   inflight = popcount of the register (always 0 when READ_LATENCY=0).
// - Request rule: fifo_rdreq = !rst & !fifo_empty & (occupancy + inflight < DEPTH).
//   Uses registered counts only; out_ready is not used.
// - Capture: fifo_q is written into buf[wr_ptr] in the cycle the delayed rdreq
//   emerges. For READ_LATENCY=0 this is the same cycle as fifo_rdreq.
//   wr_ptr increments with explicit wrap at DEPTH-1; DEPTH need not be a power of 2.
// - Pop: on out_valid & out_ready, rd_ptr increments with wrap.
// - out_valid = (occupancy != 0); out_data = buf[rd_ptr]. Both come straight from
//   registers.
// - occupancy next: +1 on capture only, -1 on pop only; unchanged on capture+pop in
//   the same cycle. Capture is never blocked, since the request rule guarantees
//   space.
// - Stream rules: once out_valid=1 it stays 1 and out_data stays stable until a
//   transfer. Order is strictly FIFO; no item is dropped or duplicated.
// - Throughput: with fifo_empty=0 and out_ready=1 held, one transfer per cycle after
//   the initial fill latency of READ_LATENCY+1 cycles.
// - Max outstanding: occupancy + inflight <= DEPTH at all times.
// - Sim assertions: no capture when occupancy==DEPTH; no fifo_rdreq when fifo_empty=1.
// TESTING
// 1. READ_LATENCY=0, FIFO preloaded with 5..14, out_ready=1 -> fifo_rdreq high for
//    10 consecutive cycles; out_data 5..14 on 10 consecutive cycles, first one
//    1 cycle after the first rdreq.
// 2. READ_LATENCY=2, 10 items preloaded, out_ready=0 -> exactly 4 rdreq pulses;
//    occupancy settles to 4; out_data=5 stays stable. Then out_ready=1 -> 5..14 in
//    order with no bubble between items.
// 3. READ_LATENCY=1, fifo_empty toggling every cycle, out_ready=1 -> rdreq never
//    asserted while empty=1; every item delivered exactly once, in order.
// 4. Assert rst asynchronously mid-burst (occupancy=3) -> out_valid and fifo_rdreq
//    drop to 0 before the next clock edge. After release, with FIFO reset and
//    reloaded with 100..103 -> out_data 100..103, no stale data.
// 5. Backpressure corner: occupancy=DEPTH, out_ready pulsed for 1 cycle with
//    fifo_empty=0 -> exactly one transfer; a new rdreq follows in the next cycle;
//    occupancy never exceeds DEPTH.
// 6. Random: READ_LATENCY in {0,1,2}, writer/reader stall policy 1..10 cycles,
//    10000 items valued i+5 through the write-delay FIFO and this adapter ->
//    consumer receives exactly 10000 items, item i == i+5.

Source files
------------

// File: rtl/fifo_read_stream_adapter.sv
// FIFO read-port to valid/ready stream adapter.
// Pops a FIFO whose read data returns READ_LATENCY cycles after rdreq and
// presents the items as a registered valid/ready stream. A small circular
// buffer of READ_LATENCY+2 entries absorbs the reads still in flight, so the
// request decision can use registered counts only and never looks at out_ready.

module fifo_read_stream_adapter_chk #(
    parameter int DEPTH = 2,
    parameter int OCC_W = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             rdreq_i,
    input  logic             empty_i,
    input  logic [OCC_W-1:0] occ_i,
    input  logic [OCC_W-1:0] inflight_i
);
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(DEPTH);

    a_no_capture_when_full: assert property (@(posedge clock) disable iff (rst)
        capture_i |-> ({1'b0, occ_i} != DEPTH_C));

    a_no_rdreq_when_empty: assert property (@(posedge clock) disable iff (rst)
        rdreq_i |-> !empty_i);

    a_outstanding_bound: assert property (@(posedge clock) disable iff (rst)
        (({1'b0, occ_i} + {1'b0, inflight_i}) <= DEPTH_C));
endmodule

module fifo_read_stream_adapter #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 0
) (
    input  logic                                 clock,
    input  logic                                 rst,
    output logic                                 fifo_rdreq,
    input  logic                                 fifo_empty,
    input  logic [WIDTH-1:0]                     fifo_q,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    output logic [$clog2(READ_LATENCY+3)-1:0]    occupancy
);
    localparam int DEPTH = READ_LATENCY + 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    // One dummy bit when there is no read latency, held at zero.
    localparam int SHR_W = (READ_LATENCY > 0) ? READ_LATENCY : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [SHR_W-1:0] infl_q, infl_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             capture_s;
    logic             pop_s;
    logic             room_s;
    logic [OCC_W-1:0] inflight_s;

    function automatic logic [OCC_W-1:0] popcount(input logic [SHR_W-1:0] v);
        logic [OCC_W-1:0] n;
        n = {OCC_W{1'b0}};
        for (int i = 0; i < SHR_W; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // The in-flight shift register delays each rdreq by READ_LATENCY cycles.
    generate
        if (READ_LATENCY <= 1) begin : g_shift_short
            assign infl_d = (READ_LATENCY == 0) ? 1'b0 : fifo_rdreq;
        end else begin : g_shift_long
            assign infl_d = {infl_q[SHR_W-2:0], fifo_rdreq};
        end
    endgenerate

    // With zero latency the data is captured in the same cycle as the request.
    assign capture_s  = (READ_LATENCY == 0) ? fifo_rdreq : infl_q[SHR_W-1];
    assign inflight_s = popcount(infl_q);
    assign pop_s      = out_valid_q && out_ready;
    assign room_s     = (({1'b0, occ_q} + {1'b0, inflight_s}) < DEPTH_C);
    assign fifo_rdreq = !rst && !fifo_empty && room_s;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign occupancy  = occ_q;

    // Next-state for pointers, occupancy and the registered stream outputs
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (capture_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : (wr_ptr_q + PTR_W'(1'b1));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : (rd_ptr_q + PTR_W'(1'b1));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({capture_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1'b1);
            2'b01:   occ_d = occ_q - OCC_W'(1'b1);
            default: occ_d = occ_q;
        endcase

        out_valid_d = (occ_d != {OCC_W{1'b0}});
        // The new head may be the word being captured right now (bypass).
        if (capture_s && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = fifo_q;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            occ_q       <= {OCC_W{1'b0}};
            infl_q      <= {SHR_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Buffer storage: FIFO read data is written when the delayed rdreq emerges
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (capture_s) begin
            mem_q[wr_ptr_q] <= fifo_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    fifo_read_stream_adapter_chk #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_chk (
        .clock      (clock),
        .rst        (rst),
        .capture_i  (capture_s),
        .rdreq_i    (fifo_rdreq),
        .empty_i    (fifo_empty),
        .occ_i      (occ_q),
        .inflight_i (inflight_s)
    );
endmodule
